// File: rtl/noc_traffic_pkg.sv
// rtl/noc_traffic_pkg.sv - shared field layout, state enums and flit builders for noc_traffic_node
package noc_traffic_pkg;

    localparam int FLIT_MAX_W = 64;

    // Header coordinate fields sit in COORD_W-wide slots; seq follows them, len follows seq.
    localparam int HDR_SRC_Y_SLOT = 0;
    localparam int HDR_SRC_X_SLOT = 1;
    localparam int HDR_DST_Y_SLOT = 2;
    localparam int HDR_DST_X_SLOT = 3;
    localparam int HDR_SEQ_SLOT   = 4;
    localparam int HDR_LEN_SHIFT  = 8;

    localparam int BODY_K_OFF     = 0;
    localparam int BODY_SEQ_OFF   = 8;
    localparam int BODY_SRC_Y_OFF = 16;

    typedef enum logic [1:0] {
        IDLE,
        HEAD,
        BODY,
        GAP
    } tx_state_t;

    typedef enum logic {
        WAIT_HDR,
        IN_PKT
    } rx_state_t;

    function automatic logic [FLIT_MAX_W-1:0] make_header(
        input logic [7:0] len,
        input logic [7:0] seq,
        input logic [7:0] dst_x,
        input logic [7:0] dst_y,
        input logic [7:0] src_x,
        input logic [7:0] src_y,
        input int         cw
    );
        logic [FLIT_MAX_W-1:0] mask;
        logic [FLIT_MAX_W-1:0] r;
        mask = (64'd1 << cw) - 64'd1;
        r = ((64'(src_y) & mask) << (HDR_SRC_Y_SLOT * cw))
          | ((64'(src_x) & mask) << (HDR_SRC_X_SLOT * cw))
          | ((64'(dst_y) & mask) << (HDR_DST_Y_SLOT * cw))
          | ((64'(dst_x) & mask) << (HDR_DST_X_SLOT * cw))
          | (64'(seq) << (HDR_SEQ_SLOT * cw))
          | (64'(len) << (HDR_SEQ_SLOT * cw + HDR_LEN_SHIFT));
        return r;
    endfunction

    function automatic logic [FLIT_MAX_W-1:0] make_body(
        input logic [7:0] src_x,
        input logic [7:0] src_y,
        input logic [7:0] seq,
        input logic [7:0] k,
        input int         cw
    );
        logic [FLIT_MAX_W-1:0] mask;
        logic [FLIT_MAX_W-1:0] r;
        mask = (64'd1 << cw) - 64'd1;
        r = (64'(k) << BODY_K_OFF)
          | (64'(seq) << BODY_SEQ_OFF)
          | ((64'(src_y) & mask) << BODY_SRC_Y_OFF)
          | ((64'(src_x) & mask) << (BODY_SRC_Y_OFF + cw));
        return r;
    endfunction

endpackage

// File: rtl/noc_traffic_checker.sv
// rtl/noc_traffic_checker.sv - RX sink and packet counters; NOC_TRAFFIC_CHECK_EN enables the packet checker
module noc_traffic_checker #(
    parameter int DATA_W  = 32,
    parameter int COORD_W = 4,
    parameter int NODE_X  = 0,
    parameter int NODE_Y  = 0
) (
    input  logic              noc_clk,
    input  logic              noc_rst,
    input  logic              rx_stall,
    input  logic              receive_valid,
    input  logic [DATA_W-1:0] receive_flit,
    input  logic              receive_is_header,
    input  logic              receive_is_tail,
    input  logic              tx_tail_fire,
    output logic              receive_ready,
    output logic [15:0]       tx_pkt_cnt,
    output logic [15:0]       rx_pkt_cnt,
    output logic [15:0]       rx_err_cnt
);
    import noc_traffic_pkg::*;

    logic rx_fire;
    logic pkt_inc;

    assign rx_fire = receive_valid & receive_ready;

    always_ff @(posedge noc_clk) begin
        if (noc_rst) begin
            receive_ready <= 1'b0;
            tx_pkt_cnt    <= '0;
            rx_pkt_cnt    <= '0;
        end else begin
            receive_ready <= !rx_stall;
            if (tx_tail_fire) tx_pkt_cnt <= tx_pkt_cnt + 16'd1;
            if (pkt_inc)      rx_pkt_cnt <= rx_pkt_cnt + 16'd1;
        end
    end

`ifdef NOC_TRAFFIC_CHECK_EN
    localparam logic [COORD_W-1:0] OWN_X = COORD_W'(NODE_X);
    localparam logic [COORD_W-1:0] OWN_Y = COORD_W'(NODE_Y);

    rx_state_t            rx_state, rx_state_n;
    logic [7:0]           len_q, len_n, seq_q, seq_n, k_q, k_n;
    logic [COORD_W-1:0]   src_x_q, src_x_n, src_y_q, src_y_n;
    logic                 err_inc;
    logic                 hdr_dst_ok;
    logic [FLIT_MAX_W-1:0] body_full;

    assign hdr_dst_ok = (receive_flit[HDR_DST_X_SLOT*COORD_W +: COORD_W] == OWN_X) &&
                        (receive_flit[HDR_DST_Y_SLOT*COORD_W +: COORD_W] == OWN_Y);
    assign body_full  = make_body(8'(src_x_q), 8'(src_y_q), seq_q, k_q, COORD_W);

    always_comb begin
        rx_state_n = rx_state;
        len_n      = len_q;
        seq_n      = seq_q;
        k_n        = k_q;
        src_x_n    = src_x_q;
        src_y_n    = src_y_q;
        err_inc    = 1'b0;
        pkt_inc    = 1'b0;
        if (rx_fire) begin
            if (receive_is_header) begin
                // A header always restarts tracking; an interrupted packet is one error.
                err_inc = (rx_state == IN_PKT) || !hdr_dst_ok;
                if (hdr_dst_ok) begin
                    rx_state_n = IN_PKT;
                    k_n        = 8'd1;
                    len_n      = receive_flit[HDR_SEQ_SLOT*COORD_W + HDR_LEN_SHIFT +: 8];
                    seq_n      = receive_flit[HDR_SEQ_SLOT*COORD_W +: 8];
                    src_x_n    = receive_flit[HDR_SRC_X_SLOT*COORD_W +: COORD_W];
                    src_y_n    = receive_flit[HDR_SRC_Y_SLOT*COORD_W +: COORD_W];
                end else begin
                    rx_state_n = WAIT_HDR;
                end
            end else if (rx_state == WAIT_HDR) begin
                err_inc = 1'b1;
            end else begin
                pkt_inc = receive_is_tail;
                if ((receive_is_tail != (k_q == len_q)) || (64'(receive_flit) != body_full)) begin
                    err_inc    = 1'b1;
                    rx_state_n = WAIT_HDR;
                end else if (receive_is_tail) begin
                    rx_state_n = WAIT_HDR;
                end else begin
                    k_n = k_q + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge noc_clk) begin
        if (noc_rst) begin
            rx_state   <= WAIT_HDR;
            len_q      <= '0;
            seq_q      <= '0;
            k_q        <= '0;
            src_x_q    <= '0;
            src_y_q    <= '0;
            rx_err_cnt <= '0;
        end else begin
            rx_state <= rx_state_n;
            len_q    <= len_n;
            seq_q    <= seq_n;
            k_q      <= k_n;
            src_x_q  <= src_x_n;
            src_y_q  <= src_y_n;
            if (err_inc && rx_err_cnt != 16'hFFFF) rx_err_cnt <= rx_err_cnt + 16'd1;
        end
    end
`else
    logic unused_rx;

    assign pkt_inc    = rx_fire & receive_is_tail;
    assign rx_err_cnt = '0;
    assign unused_rx  = ^{receive_flit, receive_is_header, NODE_X[0], NODE_Y[0], COORD_W[0]};
`endif

endmodule

// File: rtl/noc_traffic_node.sv
// rtl/noc_traffic_node.sv - NoC traffic generator/sink endpoint; checker gated by NOC_TRAFFIC_CHECK_EN
module noc_traffic_node #(
    parameter int DATA_W  = 32,
    parameter int COORD_W = 4,
    parameter int MESH_X  = 2,
    parameter int MESH_Y  = 2,
    parameter int NODE_X  = 0,
    parameter int NODE_Y  = 0,
    parameter int PKT_LEN = 3
) (
    input  logic              noc_clk,
    input  logic              noc_rst,
    input  logic              gen_en,
    input  logic [15:0]       gen_count,
    input  logic [7:0]        gen_gap,
    output logic              gen_done,
    output logic              sender_valid,
    input  logic              sender_ready,
    output logic [DATA_W-1:0] sender_flit,
    output logic              sender_is_header,
    output logic              sender_is_tail,
    input  logic              receive_valid,
    output logic              receive_ready,
    input  logic [DATA_W-1:0] receive_flit,
    input  logic              receive_is_header,
    input  logic              receive_is_tail,
    input  logic              rx_stall,
    output logic [15:0]       tx_pkt_cnt,
    output logic [15:0]       rx_pkt_cnt,
    output logic [15:0]       rx_err_cnt
);
    import noc_traffic_pkg::*;

    localparam logic [COORD_W-1:0] OWN_X = COORD_W'(NODE_X);
    localparam logic [COORD_W-1:0] OWN_Y = COORD_W'(NODE_Y);
    localparam logic [7:0]         LEN   = 8'(PKT_LEN);

    function automatic logic [2*COORD_W-1:0] step_dst(input logic [COORD_W-1:0] x,
                                                      input logic [COORD_W-1:0] y);
        logic [COORD_W-1:0] nx, ny;
        nx = x + 1'b1;
        ny = y;
        if (int'(x) == MESH_X - 1) begin
            nx = '0;
            ny = (int'(y) == MESH_Y - 1) ? '0 : y + 1'b1;
        end
        return {nx, ny};
    endfunction

    // Linear-id successor in row-major order, never landing on this node.
    function automatic logic [2*COORD_W-1:0] next_dst(input logic [COORD_W-1:0] x,
                                                      input logic [COORD_W-1:0] y);
        logic [2*COORD_W-1:0] s;
        s = step_dst(x, y);
        if (s == {OWN_X, OWN_Y}) s = step_dst(s[2*COORD_W-1:COORD_W], s[COORD_W-1:0]);
        return s;
    endfunction

    localparam logic [2*COORD_W-1:0] FIRST_DST = next_dst(OWN_X, OWN_Y);

    tx_state_t             tx_state, tx_state_n;
    logic [7:0]            seq_q, seq_n, k_q, k_n, gap_q, gap_n;
    logic [COORD_W-1:0]    dst_x_q, dst_y_q, dst_x_n, dst_y_n;
    logic [15:0]           sent_q, sent_n;
    logic                  gen_done_n, valid_n, is_hdr_n, is_tail_n;
    logic [DATA_W-1:0]     flit_n;
    logic                  tx_fire, tail_fire, done_now;
    logic [2*COORD_W-1:0]  dst_adv;
    logic [7:0]            hdr_seq, body_k;
    logic [COORD_W-1:0]    hdr_dst_x, hdr_dst_y;
    logic [FLIT_MAX_W-1:0] hdr_full, body_full;

    assign tx_fire   = sender_valid & sender_ready;
    assign tail_fire = tx_fire & sender_is_tail;
    assign dst_adv   = next_dst(dst_x_q, dst_y_q);
    assign done_now  = (gen_count != 16'd0) && (sent_q + 16'd1 == gen_count);

    // Header loaded from BODY is the back-to-back one, so it uses the advanced seq/dst.
    always_comb begin
        hdr_seq   = seq_q;
        hdr_dst_x = dst_x_q;
        hdr_dst_y = dst_y_q;
        if (tx_state == BODY) begin
            hdr_seq                = seq_q + 8'd1;
            {hdr_dst_x, hdr_dst_y} = dst_adv;
        end
        body_k    = (tx_state == HEAD) ? 8'd1 : k_q + 8'd1;
        hdr_full  = make_header(LEN, hdr_seq, 8'(hdr_dst_x), 8'(hdr_dst_y),
                                8'(OWN_X), 8'(OWN_Y), COORD_W);
        body_full = make_body(8'(OWN_X), 8'(OWN_Y), seq_q, body_k, COORD_W);
    end

    always_comb begin
        tx_state_n = tx_state;
        seq_n      = seq_q;
        dst_x_n    = dst_x_q;
        dst_y_n    = dst_y_q;
        k_n        = k_q;
        gap_n      = gap_q;
        sent_n     = sent_q;
        gen_done_n = gen_done;
        valid_n    = sender_valid;
        flit_n     = sender_flit;
        is_hdr_n   = sender_is_header;
        is_tail_n  = sender_is_tail;
        case (tx_state)
            IDLE: begin
                if (!gen_en) sent_n = '0;
                if (gen_en && !gen_done) begin
                    tx_state_n = HEAD;
                    valid_n    = 1'b1;
                    flit_n     = DATA_W'(hdr_full);
                    is_hdr_n   = 1'b1;
                    is_tail_n  = 1'b0;
                end
            end
            HEAD: begin
                if (tx_fire) begin
                    tx_state_n = BODY;
                    k_n        = 8'd1;
                    flit_n     = DATA_W'(body_full);
                    is_hdr_n   = 1'b0;
                    is_tail_n  = (LEN == 8'd1);
                end
            end
            BODY: begin
                if (tx_fire && sender_is_tail) begin
                    seq_n              = seq_q + 8'd1;
                    {dst_x_n, dst_y_n} = dst_adv;
                    sent_n             = sent_q + 16'd1;
                    if (done_now) gen_done_n = 1'b1;
                    is_tail_n = 1'b0;
                    if (gen_gap != 8'd0) begin
                        tx_state_n = GAP;
                        gap_n      = gen_gap;
                        valid_n    = 1'b0;
                    end else if (gen_en && !done_now) begin
                        tx_state_n = HEAD;
                        flit_n     = DATA_W'(hdr_full);
                        is_hdr_n   = 1'b1;
                    end else begin
                        tx_state_n = IDLE;
                        valid_n    = 1'b0;
                    end
                end else if (tx_fire) begin
                    k_n       = body_k;
                    flit_n    = DATA_W'(body_full);
                    is_tail_n = (body_k == LEN);
                end
            end
            GAP: begin
                gap_n = gap_q - 8'd1;
                if (gap_q <= 8'd1) begin
                    if (gen_en && !gen_done) begin
                        tx_state_n = HEAD;
                        valid_n    = 1'b1;
                        flit_n     = DATA_W'(hdr_full);
                        is_hdr_n   = 1'b1;
                    end else begin
                        tx_state_n = IDLE;
                    end
                end
            end
            default: tx_state_n = IDLE;
        endcase
        if (!gen_en) gen_done_n = 1'b0;
    end

    always_ff @(posedge noc_clk) begin
        if (noc_rst) begin
            tx_state         <= IDLE;
            seq_q            <= '0;
            {dst_x_q, dst_y_q} <= FIRST_DST;
            k_q              <= '0;
            gap_q            <= '0;
            sent_q           <= '0;
            gen_done         <= 1'b0;
            sender_valid     <= 1'b0;
            sender_flit      <= '0;
            sender_is_header <= 1'b0;
            sender_is_tail   <= 1'b0;
        end else begin
            tx_state         <= tx_state_n;
            seq_q            <= seq_n;
            dst_x_q          <= dst_x_n;
            dst_y_q          <= dst_y_n;
            k_q              <= k_n;
            gap_q            <= gap_n;
            sent_q           <= sent_n;
            gen_done         <= gen_done_n;
            sender_valid     <= valid_n;
            sender_flit      <= flit_n;
            sender_is_header <= is_hdr_n;
            sender_is_tail   <= is_tail_n;
        end
    end

    noc_traffic_checker #(
        .DATA_W  (DATA_W),
        .COORD_W (COORD_W),
        .NODE_X  (NODE_X),
        .NODE_Y  (NODE_Y)
    ) u_checker (
        .noc_clk           (noc_clk),
        .noc_rst           (noc_rst),
        .rx_stall          (rx_stall),
        .receive_valid     (receive_valid),
        .receive_flit      (receive_flit),
        .receive_is_header (receive_is_header),
        .receive_is_tail   (receive_is_tail),
        .tx_tail_fire      (tail_fire),
        .receive_ready     (receive_ready),
        .tx_pkt_cnt        (tx_pkt_cnt),
        .rx_pkt_cnt        (rx_pkt_cnt),
        .rx_err_cnt        (rx_err_cnt)
    );

endmodule

// File: doc/noc_traffic_node.md
# noc_traffic_node

Parametrised traffic endpoint for the mesh NoC simulation top, replacing the passive empty node at any mesh coordinate. It generates framed header/body/tail packets toward every other node in round-robin order, with programmable count and inter-packet gap. It also sinks inbound packets, counts them and checks them. One instance per node port of the NoC connector.

## Interface
Parameters:
- DATA_W, 32: flit width; must be ≥ 4*COORD_W+16.
- COORD_W, 4: width of each x/y coordinate field.
- MESH_X, 2: mesh columns.
- MESH_Y, 2: mesh rows.
- NODE_X, 0: own x coordinate.
- NODE_Y, 0: own y coordinate.
- PKT_LEN, 3: flits after the header, tail included; range 1..255.

Ports:
- noc_clk  in  1  clock.
- noc_rst  in  1  reset, synchronous, active-high.
- gen_en  in  1  generator enable.
- gen_count  in  16  packets to send; 0 means unlimited.
- gen_gap  in  8  idle cycles after each tail handshake.
- gen_done  out  1  gen_count packets sent.
- sender_valid / sender_ready / sender_flit[DATA_W] / sender_is_header / sender_is_tail  out/in/out/out/out: flit stream into the router.
- receive_valid / receive_ready / receive_flit[DATA_W] / receive_is_header / receive_is_tail  in/out/in/in/in: flit stream from the router.
- rx_stall  in  1  forces receive_ready low.
- tx_pkt_cnt  out  16  tail handshakes sent; wraps.
- rx_pkt_cnt  out  16  tails accepted in-packet; wraps.
- rx_err_cnt  out  16  protocol/payload errors; saturates at 16'hFFFF.

## Operation
- Header flit, zero-extended: {len[7:0], seq[7:0], dst_x, dst_y, src_x, src_y}, with src_y at bit 0.
- Body flit k (k = 1..len), zero-extended: {src_x, src_y, seq[7:0], k[7:0]}. Flit k = len carries is_tail = 1.
- Destination order: linear id = y*MESH_X + x. Starts at own id + 1, increments per packet, wraps at MESH_X*MESH_Y and skips own id. seq starts at 0 and increments per packet, wrapping at 8 bits.
- TX FSM:
  - IDLE → HEAD when gen_en = 1 and gen_done = 0.
  - HEAD → BODY on handshake.
  - BODY → BODY on each handshake until flit len.
  - On the tail handshake → GAP if gen_gap ≠ 0, otherwise directly HEAD/IDLE.
  - GAP counts gen_gap cycles, then → HEAD if gen_en = 1 and the count is not reached, else IDLE.
- gen_en deasserted mid-packet: the current packet completes, then IDLE.
- gen_done sets on the tail handshake that makes tx_pkt_cnt-since-start equal gen_count (gen_count ≠ 0). It clears when gen_en = 0.
- Handshake: a transfer occurs when valid & ready. While valid is high and ready is low, flit and flags hold stable. Valid never drops without a transfer, except at reset.
- RX: receive_ready = !rx_stall. A tail accepted while in a packet increments rx_pkt_cnt.

## Timing
- All outputs are registered. Reset values: every output 0 and counters 0; receive_ready follows the registered !rx_stall and is 0 during reset.
- First header valid one cycle after gen_en is sampled high in IDLE.
- Zero-gap packets are back-to-back: the next header is valid the cycle after the tail handshake.
- Counters update the cycle after the causing handshake.
- Reset mid-packet: sender_valid is 0 after the reset edge. The FSM, seq, destination pointer and checker state return to their initial values.

## Configuration
- NOC_TRAFFIC_CHECK_EN defined: the checker is active. Each of the following counts one error, and the checker then returns to WAIT_HDR:
  - header dst ≠ own coordinates;
  - body/tail with no header;
  - tail at k ≠ len;
  - non-tail at k = len;
  - body payload mismatch.
- A header arriving in-packet counts one error and starts a new packet.
- NOC_TRAFFIC_CHECK_EN undefined: no checker logic; rx_err_cnt is tied to 0. rx_pkt_cnt counts every accepted tail.

## Structure
- Package noc_traffic_pkg contains:
  - header and body field offset constants;
  - the TX state enum (IDLE, HEAD, BODY, GAP) and the RX state enum (WAIT_HDR, IN_PKT);
  - functions make_header and make_body.
- Sub-module noc_traffic_checker implements the RX side and the counters. It is compiled empty of check logic when the macro is off.

## Test plan
- Reset with gen_en = 1 held → all outputs 0 while noc_rst = 1; first header appears one cycle after reset release.
- Node (0,0), 2x2 mesh, PKT_LEN 3, gen_count 2, gen_gap 0, ready = 1:
  - first packet is 0x03001000, 0x00000001, 0x00000002, 0x00000003 (tail);
  - second header is 0x03010100;
  - gen_done = 1 and tx_pkt_cnt = 2.
- sender_ready low for 3 cycles while body 2 is valid → flit 0x00000002 is held stable with valid high; the sequence completes unchanged.
- Inbound 0x02050011, 0x00110501, 0x00110502 (tail), with the check macro on → rx_pkt_cnt = 1, rx_err_cnt = 0.
- Inbound header 0x02050011 followed by tail 0x00110501 → rx_err_cnt = 1. A following bare body flit → rx_err_cnt = 2.
- gen_en dropped after the header handshake → all remaining body/tail flits are still sent, then the FSM goes IDLE with no further header.
